// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM states, side constants and default sizing for the pong core
package pong_pkg;
  typedef enum logic [2:0] {IDLE, SERVE, MOVE_R, MOVE_L, POINT, GAME_OVER} state_e;
  localparam logic LEFT = 1'b0;
  localparam logic RIGHT = 1'b1;
  localparam int DEF_NUM_LEDS = 8;
  localparam int DEF_WIN_SCORE = 9;
endpackage

// File: rtl/btn_rise_det.sv
// btn_rise_det: one-cycle pulse on the rising edge of a synchronised button level
module btn_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);
  logic btn_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) btn_q <= 1'b0;
    else btn_q <= btn_i;
  assign rise_o = btn_i & ~btn_q;
endmodule

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: ball FSM, paddle hit detection and scoring for a one-row LED pong game
module pong_ball_ctrl import pong_pkg::*; #(
  parameter int NUM_LEDS    = DEF_NUM_LEDS,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int PAUSE_TICKS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic                btn_l,
  input  logic                btn_r,
  output logic [NUM_LEDS-1:0] leds,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic                game_over,
  output logic                winner
);
  localparam int PW = $clog2(NUM_LEDS);
  localparam int CW = $clog2(PAUSE_TICKS + 1);
  localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [NUM_LEDS-1:0] ONE = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] HALF = NUM_LEDS'((1 << (NUM_LEDS / 2)) - 1);
  state_e state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [SCORE_W-1:0] sl_q, sl_d, sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic server_q, server_d, win_q, win_d, go_q;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic rise_l, rise_r;
  btn_rise_det u_rise_l (.clk(clk), .reset(reset), .btn_i(btn_l), .rise_o(rise_l));
  btn_rise_det u_rise_r (.clk(clk), .reset(reset), .btn_i(btn_r), .rise_o(rise_r));
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    server_d = server_q;
    sl_d = sl_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    win_d = win_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SERVE;
        pos_d = '0;
        server_d = LEFT;
      end
      SERVE: if (server_q == LEFT ? rise_l : rise_r) state_d = server_q == LEFT ? MOVE_R : MOVE_L;
      // A receiver press only counts as a hit at the paddle end; anywhere else it is a fault
      MOVE_R:
        if (rise_r && pos_q == LAST) state_d = MOVE_L;
        else if (rise_r || (tick && pos_q == LAST)) begin
          sl_d = sl_q + 1'b1;
          server_d = RIGHT;
          cnt_d = '0;
          state_d = POINT;
        end else if (tick) pos_d = pos_q + 1'b1;
      MOVE_L:
        if (rise_l && pos_q == '0) state_d = MOVE_R;
        else if (rise_l || (tick && pos_q == '0)) begin
          sr_d = sr_q + 1'b1;
          server_d = LEFT;
          cnt_d = '0;
          state_d = POINT;
        end else if (tick) pos_d = pos_q - 1'b1;
      POINT: if (tick) begin
        if (cnt_q != CW'(PAUSE_TICKS - 1)) cnt_d = cnt_q + 1'b1;
        else if (sl_q == WIN || sr_q == WIN) begin
          state_d = GAME_OVER;
          win_d = sr_q == WIN;
        end else begin
          state_d = SERVE;
          pos_d = server_q == LEFT ? '0 : LAST;
        end
      end
      GAME_OVER: if (start) begin
        sl_d = '0;
        sr_d = '0;
        server_d = LEFT;
        pos_d = '0;
        state_d = SERVE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign leds_d = state_d == IDLE ? '0 :
                  state_d == POINT ? '1 :
                  state_d == GAME_OVER ? (win_d ? ~HALF : HALF) : ONE << pos_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      pos_q <= '0;
      server_q <= LEFT;
      sl_q <= '0;
      sr_q <= '0;
      cnt_q <= '0;
      win_q <= 1'b0;
      leds_q <= '0;
      go_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      server_q <= server_d;
      sl_q <= sl_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      win_q <= win_d;
      leds_q <= leds_d;
      go_q <= state_d == GAME_OVER;
    end
  assign leds = leds_q;
  assign score_l = sl_q;
  assign score_r = sr_q;
  assign game_over = go_q;
  assign winner = win_q;
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: directed table, corner sequences and random play against a game-level model
module tb_pong_ball_ctrl;
  localparam int N = 8;
  localparam int WIN = 3;
  localparam int PAUSE = 2;
  logic clk = 0, reset = 1, tick = 0, start = 0, btn_l = 0, btn_r = 0;
  logic [N-1:0] leds;
  logic [3:0] score_l, score_r;
  logic game_over, winner;
  int n_vec = 0, n_bad = 0;
  pong_ball_ctrl #(.NUM_LEDS(N), .SCORE_W(4), .WIN_SCORE(WIN), .PAUSE_TICKS(PAUSE)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .btn_l(btn_l), .btn_r(btn_r),
    .leds(leds), .score_l(score_l), .score_r(score_r), .game_over(game_over), .winner(winner)
  );
  always #5 clk = ~clk;
  // game model: mode 0 idle, 1 serve, 2 rally, 3 pause after point, 4 game over
  int m_mode, m_pos, m_dir, m_srv, m_sl, m_sr, m_pause, m_win;
  bit m_pl, m_pr;
  task automatic m_reset();
    m_mode = 0; m_pos = 0; m_dir = 1; m_srv = 0; m_sl = 0; m_sr = 0; m_pause = 0; m_win = 0;
    m_pl = 0; m_pr = 0;
  endtask
  task automatic m_step(input bit t, input bit s, input bit bl, input bit br);
    bit rl, rr, hit_btn;
    int far;
    rl = bl && !m_pl;
    rr = br && !m_pr;
    m_pl = bl;
    m_pr = br;
    case (m_mode)
      0: if (s) begin m_mode = 1; m_pos = 0; m_srv = 0; end
      1: if (m_srv == 1 ? rr : rl) begin m_mode = 2; m_dir = m_srv == 1 ? -1 : 1; end
      2: begin
        far = m_dir > 0 ? N - 1 : 0;
        hit_btn = m_dir > 0 ? rr : rl;
        if (hit_btn && m_pos == far) m_dir = -m_dir;
        else if (hit_btn || (t && m_pos == far)) begin
          if (m_dir > 0) m_sl++; else m_sr++;
          m_srv = m_dir > 0 ? 1 : 0;
          m_mode = 3;
          m_pause = 0;
        end else if (t) m_pos += m_dir;
      end
      3: if (t) begin
        m_pause++;
        if (m_pause == PAUSE) begin
          if (m_sl == WIN || m_sr == WIN) begin m_mode = 4; m_win = m_sr == WIN; end
          else begin m_mode = 1; m_pos = m_srv == 1 ? N - 1 : 0; end
        end
      end
      default: if (s) begin m_mode = 1; m_sl = 0; m_sr = 0; m_srv = 0; m_pos = 0; end
    endcase
  endtask
  function automatic logic [N-1:0] m_leds();
    case (m_mode)
      0: return '0;
      1, 2: return 8'h01 << m_pos;
      3: return 8'hFF;
      default: return m_win != 0 ? 8'hF0 : 8'h0F;
    endcase
  endfunction
  task automatic check(input string name, input logic [N-1:0] el, input int esl, input int esr,
                       input logic ego, input logic ewin);
    n_vec++;
    if (leds !== el || score_l !== 4'(esl) || score_r !== 4'(esr) || game_over !== ego ||
        (ego && winner !== ewin)) begin
      n_bad++;
      $display("FAIL %s: got leds=%h sl=%0d sr=%0d go=%b win=%b, want leds=%h sl=%0d sr=%0d go=%b win=%b",
               name, leds, score_l, score_r, game_over, winner, el, esl, esr, ego, ewin);
    end
  endtask
  task automatic cyc(input bit t, input bit s, input bit bl, input bit br);
    tick = t; start = s; btn_l = bl; btn_r = br;
    m_step(t, s, bl, br);
    @(posedge clk); #1;
    check("model", m_leds(), m_sl, m_sr, m_mode == 4, m_win[0]);
  endtask
  task automatic ticks(input int n, input bit bl, input bit br);
    repeat (n) begin
      cyc(1, 0, bl, br);
      repeat (3) cyc(0, 0, bl, br);
    end
  endtask
  task automatic press(input bit bl, input bit br);
    cyc(0, 0, bl, br);
    cyc(0, 0, 0, 0);
  endtask
  typedef struct {
    bit t, s, bl, br;
    logic [N-1:0] el;
    int esl, esr;
  } vec_t;
  vec_t tbl[18];
  bit rbl, rbr;
  initial begin
    tbl[0]  = '{0, 0, 0, 0, 8'h00, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 8'h01, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 8'h01, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 8'h02, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 8'h04, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 8'h08, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 8'h10, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 8'h20, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 8'h40, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 8'h80, 0, 0};
    tbl[10] = '{1, 0, 0, 1, 8'h80, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 8'h80, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 8'h40, 0, 0};
    tbl[13] = '{0, 0, 1, 0, 8'hFF, 0, 1};
    tbl[14] = '{1, 0, 1, 0, 8'hFF, 0, 1};
    tbl[15] = '{1, 0, 0, 0, 8'h01, 0, 1};
    tbl[16] = '{0, 0, 0, 1, 8'h01, 0, 1};
    tbl[17] = '{1, 0, 0, 1, 8'h01, 0, 1};
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 8'h00, 0, 0, 1'b0, 1'b0);
    reset = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].t, tbl[i].s, tbl[i].bl, tbl[i].br);
      check($sformatf("table%0d", i), tbl[i].el, tbl[i].esl, tbl[i].esr, 1'b0, 1'b0);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    ticks(5, 0, 0);
    check("pos5", 8'h20, 0, 1, 1'b0, 1'b0);
    reset = 1;
    #1;
    m_reset();
    check("async_reset", 8'h00, 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    cyc(0, 1, 0, 0);
    check("start_after_reset", 8'h01, 0, 0, 1'b0, 1'b0);
    press(1, 0);
    ticks(4, 0, 0);
    cyc(0, 0, 0, 1);
    check("early_fault", 8'hFF, 1, 0, 1'b0, 1'b0);
    cyc(0, 0, 0, 0);
    ticks(2, 0, 0);
    check("right_serves", 8'h80, 1, 0, 1'b0, 1'b0);
    repeat (2) begin
      press(0, 1);
      ticks(7, 0, 0);
      press(1, 0);
      ticks(8, 0, 0);
      ticks(2, 0, 0);
    end
    check("game_over", 8'h0F, 3, 0, 1'b1, 1'b0);
    cyc(0, 1, 0, 0);
    check("restart", 8'h01, 0, 0, 1'b0, 1'b0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    ticks(7, 0, 1);
    check("held_r_no_fault", 8'h80, 0, 0, 1'b0, 1'b0);
    ticks(1, 0, 1);
    check("held_r_miss", 8'hFF, 1, 0, 1'b0, 1'b0);
    rbl = 0;
    rbr = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        tick = 0; start = 0; btn_l = 0; btn_r = 0; rbl = 0; rbr = 0;
        reset = 1;
        m_reset();
        @(posedge clk); #1;
        reset = 0;
        check("rand_reset", 8'h00, 0, 0, 1'b0, 1'b0);
      end else begin
        if ($urandom_range(0, 5) == 0) rbl = ~rbl;
        if ($urandom_range(0, 5) == 0) rbr = ~rbr;
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, rbl, rbr);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pong_ball_ctrl.md
Name: pong_ball_ctrl

Overview:
- Ping-pong game core. Consumes the one-cycle game-rate tick from the clock-divider stage and advances a ball across an LED row.
- Detects paddle hits from the two player buttons and keeps the score.
- Drives the LED row and the score/winner outputs that feed the display stage.
- Single clock domain; all state advances on the tick, button edges, or start.

Parameters:
- NUM_LEDS, 8: LED row length; pos 0 = left paddle end, pos NUM_LEDS-1 = right paddle end.
- SCORE_W, 4: width of each score counter.
- WIN_SCORE, 9: points that end the game; must be < 2**SCORE_W.
- PAUSE_TICKS, 2: ticks spent in POINT before the next serve.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle enable pulse from the rate divider; may be high on any cycle.
- start  in  1  synchronous level; starts or restarts a game.
- btn_l  in  1  left player button, already synchronised and debounced; level.
- btn_r  in  1  right player button, same properties as btn_l.
- leds  out  NUM_LEDS  ball display; one-hot leds[pos] while in play.
- score_l  out  SCORE_W  left score.
- score_r  out  SCORE_W  right score.
- game_over  out  1  high in GAME_OVER.
- winner  out  1  0 = left, 1 = right; valid only while game_over=1.

Behaviour:
- Reset (async, active-high, all registers):
  - state=IDLE, pos=0, server=left, scores=0, pause count=0.
  - leds=0, game_over=0, winner=0, button edge history=0.
- Reset asserted mid-rally aborts immediately; no score is committed.
- Clock and reset are the only async inputs.
- All outputs are registered. A button edge sampled in cycle N is reflected in the outputs after edge N+1.
- Button rise detection: rise_x = btn_x & ~btn_x_q. A held button produces one rise only.
- IDLE:
  - leds=0.
  - start=1 → SERVE, pos=0, server=left.
- SERVE:
  - Ball sits at the server end: pos=0 for left, NUM_LEDS-1 for right. leds show pos.
  - Server's rise → MOVE away from the server.
  - Receiver's rise is ignored. tick is ignored.
- MOVE_R (ball travelling toward the right paddle):
  - If rise_r and pos<NUM_LEDS-1: early-swing fault. score_l++ → POINT, server=right.
  - If rise_r and pos==NUM_LEDS-1: hit → MOVE_L. pos is unchanged this cycle.
  - Else if tick and pos<NUM_LEDS-1: pos++.
  - Else if tick and pos==NUM_LEDS-1 (no hit): miss. score_l++ → POINT, server=right.
  - Hit beats tick in the same cycle; the bounce wins.
  - rise_l is ignored in MOVE_R.
- MOVE_L: mirror of MOVE_R, with pos decrementing toward 0, btn_l as the receiver, and score_r incremented on fault or miss.
- POINT:
  - leds = all ones.
  - Counts PAUSE_TICKS ticks. The counter is cleared on entry.
  - On the last tick:
    - If either score == WIN_SCORE → GAME_OVER, winner = scorer.
    - Else → SERVE.
  - The loser of the point serves next.
- GAME_OVER:
  - game_over=1. leds = all ones on the winner's half, zeros elsewhere.
  - Scores hold.
  - start=1 → scores=0, game_over=0, server=left → SERVE.
- start is ignored in SERVE, MOVE_*, and POINT.
- Scores never exceed WIN_SCORE, so no wrap logic is needed.

Decomposition:
- Package pong_pkg:
  - State enum: IDLE, SERVE, MOVE_R, MOVE_L, POINT, GAME_OVER.
  - Side constants: LEFT=0, RIGHT=1.
  - Default NUM_LEDS and WIN_SCORE.
- Sub-module btn_rise_det:
  - Register plus AND-NOT, asynchronous reset to 0.
  - Instantiated twice, once for btn_l and once for btn_r.

Test Plan (NUM_LEDS=8, WIN_SCORE=3, PAUSE_TICKS=2, tick every 4 cycles):
- Reset mid-MOVE_R with pos=5 → next cycle leds=0, scores 0, state IDLE. Releasing reset, then start → leds=8'b0000_0001.
- Serve left, then 7 ticks → leds walk 0x01→0x80. rise_r while pos=7 → MOVE_L; next tick leds=0x40.
- At pos=7, tick and rise_r in the same cycle → bounce, leds stay 0x80 for one cycle, no score change.
- Rally toward right, rise_r at pos=4 → score_l=1, leds=0xFF. After 2 ticks → SERVE with leds=0x80 (right serves).
- At pos=7 without hit, next tick → miss, score_l increments. Repeat to score_l=3 → after pause game_over=1, winner=0, leds=0x0F. start → scores 0, SERVE, leds=0x01.
- btn_r held high through the whole rally → exactly one rise; fault only if that rise occurs before pos=7. Holding btn_l in SERVE while the right player serves → no effect.
